// File: rtl/nmr_shot_scheduler.sv
// Purpose: sequences NMRPulseSequencer shots (averaging and CPMG BBdly sweeps), counting pulses, waiting for capture, then a repetition delay.
// Latency: a shot starts 2 cycles after start (IDLE->ARM->RUN); ACQ->REP takes 1 cycle once capture is flagged; REP lasts max(1, trep*US_DIVIDER) cycles.
// Backpressure: none; start is ignored while busy, abort returns to IDLE next cycle, and RUN waits for pulses indefinitely.
//
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   start, abort           : one-cycle run control requests
//   shots_in, steps_in     : shots per step, sweep steps (0 treated as 1), latched on start
//   bbdly_start_in/step_in : BBdly for step 0 and per-step increment (us), latched on start
//   bbcnt_in, trep_in      : B pulses per shot, repetition delay (us), latched on start
//   pulse_in, acq_done     : sequencer pulse output, capture-complete indication
//   seq_rst, seq_bbdly     : sequencer reset and BBdly drive
//   shot_strobe, done      : one-cycle shot-start and run-complete pulses
//   busy, step_idx, shot_idx : run status and current position
module nmr_shot_scheduler #(
  parameter int US_DIVIDER = 125,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      shots_in,
  input  logic [15:0]      steps_in,
  input  logic [CNT_W-1:0] bbdly_start_in,
  input  logic [CNT_W-1:0] bbdly_step_in,
  input  logic [15:0]      bbcnt_in,
  input  logic [CNT_W-1:0] trep_in,
  input  logic             pulse_in,
  input  logic             acq_done,
  output logic             seq_rst,
  output logic [CNT_W-1:0] seq_bbdly,
  output logic             shot_strobe,
  output logic             busy,
  output logic             done,
  output logic [15:0]      step_idx,
  output logic [15:0]      shot_idx
);

  localparam int               PRE_W   = (US_DIVIDER > 1) ? $clog2(US_DIVIDER) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(US_DIVIDER - 1);
  localparam logic [CNT_W-1:0] ONE_US  = CNT_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_ACQ, S_REP, S_FIN} state_t;

  state_t           r_state;
  logic [15:0]      r_shots;
  logic [15:0]      r_steps;
  logic [15:0]      r_bbcnt;
  logic [CNT_W-1:0] r_bbdly_step;
  logic [CNT_W-1:0] r_trep;
  logic [CNT_W-1:0] r_us_cnt;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [16:0]      r_edge_cnt;
  logic             r_pulse_q;
  logic             r_acq_flag;

  logic        w_fall;
  logic [16:0] w_edge_next;
  logic [16:0] w_edge_target;
  logic        w_rep_last;
  logic        w_more_shots;
  logic        w_more_steps;

  assign w_fall        = r_pulse_q & ~pulse_in;
  assign w_edge_next   = r_edge_cnt + 17'd1;
  // A pulse plus bbcnt B pulses; 17 bits so bbcnt=0xFFFF does not wrap.
  assign w_edge_target = {1'b0, r_bbcnt} + 17'd1;
  // trep=0 still spends one cycle in REP.
  assign w_rep_last    = (r_trep == '0) ||
                         ((r_pre_cnt == PRE_MAX) && (r_us_cnt == r_trep - ONE_US));
  // r_shots/r_steps are latched as at least 1, so the subtraction cannot underflow.
  assign w_more_shots  = shot_idx < (r_shots - 16'd1);
  assign w_more_steps  = step_idx < (r_steps - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      seq_rst      <= 1'b1;
      seq_bbdly    <= '0;
      shot_strobe  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      step_idx     <= '0;
      shot_idx     <= '0;
      r_shots      <= 16'd1;
      r_steps      <= 16'd1;
      r_bbcnt      <= '0;
      r_bbdly_step <= '0;
      r_trep       <= '0;
      r_us_cnt     <= '0;
      r_pre_cnt    <= '0;
      r_edge_cnt   <= '0;
      r_pulse_q    <= 1'b0;
      r_acq_flag   <= 1'b0;
    end else begin
      shot_strobe <= 1'b0;
      done        <= 1'b0;
      r_pulse_q   <= pulse_in;
      // Capture may finish before the last pulse is counted, so remember it.
      if ((r_state == S_RUN || r_state == S_ACQ) && acq_done) begin
        r_acq_flag <= 1'b1;
      end

      if (abort && r_state != S_IDLE) begin
        // Indices and seq_bbdly deliberately hold for post-mortem inspection.
        r_state <= S_IDLE;
        seq_rst <= 1'b1;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            seq_rst <= 1'b1;
            busy    <= 1'b0;
            if (start && !abort) begin
              r_shots      <= (shots_in == 16'd0) ? 16'd1 : shots_in;
              r_steps      <= (steps_in == 16'd0) ? 16'd1 : steps_in;
              r_bbcnt      <= bbcnt_in;
              r_bbdly_step <= bbdly_step_in;
              r_trep       <= trep_in;
              seq_bbdly    <= bbdly_start_in;
              step_idx     <= '0;
              shot_idx     <= '0;
              busy         <= 1'b1;
              r_state      <= S_ARM;
            end
          end
          S_ARM: begin
            // Clearing the pulse history hides any pulse seen during REP/IDLE.
            r_pulse_q   <= 1'b0;
            r_edge_cnt  <= '0;
            r_acq_flag  <= 1'b0;
            seq_rst     <= 1'b0;
            shot_strobe <= 1'b1;
            r_state     <= S_RUN;
          end
          S_RUN: begin
            if (w_fall) begin
              r_edge_cnt <= w_edge_next;
              if (w_edge_next == w_edge_target) begin
                r_state <= S_ACQ;
              end
            end
          end
          S_ACQ: begin
            if (r_acq_flag) begin
              seq_rst   <= 1'b1;
              r_pre_cnt <= '0;
              r_us_cnt  <= '0;
              r_state   <= S_REP;
            end
          end
          S_REP: begin
            if (w_rep_last) begin
              if (w_more_shots) begin
                shot_idx <= shot_idx + 16'd1;
                r_state  <= S_ARM;
              end else if (w_more_steps) begin
                shot_idx  <= '0;
                step_idx  <= step_idx + 16'd1;
                seq_bbdly <= seq_bbdly + r_bbdly_step;
                r_state   <= S_ARM;
              end else begin
                done    <= 1'b1;
                r_state <= S_FIN;
              end
            end else if (r_pre_cnt == PRE_MAX) begin
              r_pre_cnt <= '0;
              r_us_cnt  <= r_us_cnt + ONE_US;
            end else begin
              r_pre_cnt <= r_pre_cnt + PRE_W'(1);
            end
          end
          S_FIN: begin
            seq_rst <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            seq_rst <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nmr_shot_scheduler.sv
// Purpose: self-checking bench for nmr_shot_scheduler with a pulse/capture responder and shot scoreboard.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_nmr_shot_scheduler;
  localparam int US = 5;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] shots_in, steps_in, bbcnt_in;
  logic [31:0] bbdly_start_in, bbdly_step_in, trep_in;
  logic        pulse_in, acq_done;
  logic        seq_rst, shot_strobe, busy, done;
  logic [31:0] seq_bbdly;
  logic [15:0] step_idx, shot_idx;

  always #5 clk = ~clk;

  nmr_shot_scheduler #(.US_DIVIDER(US), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .shots_in(shots_in), .steps_in(steps_in),
    .bbdly_start_in(bbdly_start_in), .bbdly_step_in(bbdly_step_in),
    .bbcnt_in(bbcnt_in), .trep_in(trep_in),
    .pulse_in(pulse_in), .acq_done(acq_done),
    .seq_rst(seq_rst), .seq_bbdly(seq_bbdly), .shot_strobe(shot_strobe),
    .busy(busy), .done(done), .step_idx(step_idx), .shot_idx(shot_idx)
  );

  typedef struct {
    logic [15:0] shots;
    logic [15:0] steps;
    logic [31:0] bbdly_start;
    logic [31:0] bbdly_step;
    logic [15:0] bbcnt;
    logic [31:0] trep;
    bit          early;
    bit          spam;
    int          exp_strobes;
    logic [31:0] exp_last_bbdly;
  } run_vec_t;

  typedef struct {
    logic [15:0] step;
    logic [15:0] shot;
    logic [31:0] bbdly;
  } sb_t;

  sb_t         sb_q[$];
  run_vec_t    tbl[6];
  int          n_checks = 0, n_errors = 0;
  int          n_strobe = 0, n_done = 0;
  int          exp_rep = 1, exp_low = 0;
  int          rep_cnt = 0, low_cnt = 0;
  bit          first_shot = 1'b1;
  logic [31:0] last_bbdly = '0;
  sb_t         mon_e;

  // Responder: emulates the sequencer's pulse train and the capture block.
  bit   resp_en = 1'b0, rsp_early = 1'b0;
  int   cfg_n = 1;
  logic rsp_pulse, rsp_acq, man_pulse;
  assign pulse_in = resp_en ? rsp_pulse : man_pulse;
  assign acq_done = resp_en & rsp_acq;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pulse high 2 cycles / low 2 cycles; normal capture ends 10 cycles after
  // the last fall, early capture fires right after the first fall and then a
  // stray pulse is emitted during the repetition delay.
  initial begin
    rsp_pulse = 1'b0;
    rsp_acq   = 1'b0;
    forever begin
      cyc();
      if (resp_en && busy && !seq_rst) begin
        for (int p = 0; p < cfg_n; p++) begin
          rsp_pulse = 1'b1;
          cyc(); cyc();
          rsp_pulse = 1'b0;
          if (rsp_early && p == 0) rsp_acq = 1'b1;
          cyc();
          rsp_acq = 1'b0;
          if (p != cfg_n - 1) cyc();
        end
        if (!rsp_early) begin
          repeat (9) cyc();
          rsp_acq = 1'b1;
          cyc();
          rsp_acq = 1'b0;
        end
        while (resp_en && !seq_rst) cyc();
        if (resp_en && rsp_early) begin
          rsp_pulse = 1'b1;
          cyc(); cyc();
          rsp_pulse = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard pops on shot_strobe, measures seq_rst-low span per
  // shot (RUN+ACQ) and the REP length before each following shot or done.
  always begin
    @(posedge clk);
    #2;
    if (rst || !busy) begin
      rep_cnt = 0; low_cnt = 0; first_shot = 1'b1;
    end else if (!seq_rst) begin
      if (shot_strobe) begin
        n_strobe++;
        last_bbdly = seq_bbdly;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_shot", 64'd1, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("step_idx", 64'(step_idx), 64'(mon_e.step));
          check("shot_idx", 64'(shot_idx), 64'(mon_e.shot));
          check("seq_bbdly", 64'(seq_bbdly), 64'(mon_e.bbdly));
        end
        if (!first_shot) check("rep_len", 64'(rep_cnt - 1), 64'(exp_rep));
        first_shot = 1'b0;
      end
      rep_cnt = 0;
      low_cnt++;
    end else begin
      if (low_cnt != 0) begin
        if (exp_low != 0) check("low_len", 64'(low_cnt), 64'(exp_low));
        low_cnt = 0;
      end
      if (done) begin
        n_done++;
        check("rep_len_last", 64'(rep_cnt), 64'(exp_rep));
        check("sb_drained", 64'(sb_q.size()), 64'd0);
      end else begin
        rep_cnt++;
      end
    end
  end

  task automatic set_inputs(input run_vec_t v);
    shots_in = v.shots; steps_in = v.steps; bbcnt_in = v.bbcnt;
    bbdly_start_in = v.bbdly_start; bbdly_step_in = v.bbdly_step; trep_in = v.trep;
    cfg_n     = int'(v.bbcnt) + 1;
    rsp_early = v.early;
    exp_rep   = (v.trep == 0) ? 1 : int'(v.trep) * US;
    exp_low   = 4 * cfg_n + (v.early ? 0 : 10);
  endtask

  task automatic push_expected(input run_vec_t v);
    int  sh_e, st_e;
    sb_t e;
    sh_e = (v.shots == 0) ? 1 : int'(v.shots);
    st_e = (v.steps == 0) ? 1 : int'(v.steps);
    for (int s = 0; s < st_e; s++) begin
      for (int k = 0; k < sh_e; k++) begin
        e.step  = 16'(s);
        e.shot  = 16'(k);
        e.bbdly = v.bbdly_start + 32'(s) * v.bbdly_step;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic run_vec(input run_vec_t v, input int idx);
    bit seen;
    seen = 1'b0;
    push_expected(v);
    set_inputs(v);
    resp_en  = 1'b1;
    n_strobe = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      cyc();
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (v.spam) begin
        start = (i % 7 == 3);
        shots_in = 16'd9; steps_in = 16'd7; bbcnt_in = 16'd5;
        bbdly_start_in = 32'hDEAD; bbdly_step_in = 32'h77; trep_in = 32'd9;
      end
    end
    start = 1'b0;
    check($sformatf("run%0d_done_seen", idx), 64'(seen), 64'd1);
    check($sformatf("run%0d_busy_at_done", idx), 64'(busy), 64'd1);
    check($sformatf("run%0d_strobes", idx), 64'(n_strobe), 64'(v.exp_strobes));
    check($sformatf("run%0d_last_bbdly", idx), 64'(last_bbdly), 64'(v.exp_last_bbdly));
    cyc();
    check($sformatf("run%0d_busy_after", idx), 64'(busy), 64'd0);
    check($sformatf("run%0d_done_width", idx), 64'(done), 64'd0);
    check($sformatf("run%0d_seq_rst_idle", idx), 64'(seq_rst), 64'd1);
    resp_en = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int nd0;
    run_vec_t v;

    tbl[0] = '{16'd1, 16'd1, 32'd1000, 32'd0, 16'd2, 32'd3, 1'b0, 1'b0, 1, 32'd1000};
    tbl[1] = '{16'd2, 16'd3, 32'd1500, 32'd100, 16'd1, 32'd1, 1'b0, 1'b0, 6, 32'd1700};
    tbl[2] = '{16'd2, 16'd1, 32'd40, 32'd0, 16'd2, 32'd2, 1'b1, 1'b0, 2, 32'd40};
    tbl[3] = '{16'd0, 16'd0, 32'd7, 32'd0, 16'd0, 32'd0, 1'b0, 1'b0, 1, 32'd7};
    tbl[4] = '{16'd1, 16'd2, 32'hFFFF_FFF0, 32'h20, 16'd1, 32'd1, 1'b0, 1'b0, 2, 32'h10};
    tbl[5] = '{16'd2, 16'd2, 32'd300, 32'd25, 16'd1, 32'd2, 1'b0, 1'b1, 4, 32'd325};

    rst = 1'b1; start = 1'b0; abort = 1'b0; man_pulse = 1'b0;
    shots_in = '0; steps_in = '0; bbcnt_in = '0;
    bbdly_start_in = '0; bbdly_step_in = '0; trep_in = '0;
    repeat (3) cyc();
    check("reset_seq_rst", 64'(seq_rst), 64'd1);
    check("reset_bbdly", 64'(seq_bbdly), 64'd0);
    check("reset_flags", 64'({shot_strobe, busy, done}), 64'd0);
    check("reset_idx", 64'({step_idx, shot_idx}), 64'd0);
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i], i);
      repeat (3) cyc();
    end

    // Abort mid-RUN after one of three pulses.
    v = '{16'd1, 16'd1, 32'h1234, 32'd0, 16'd2, 32'd1, 1'b0, 1'b0, 1, 32'h1234};
    push_expected(v);
    set_inputs(v);
    exp_low = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    check("abort_strobe", 64'(shot_strobe), 64'd1);
    man_pulse = 1'b1; cyc(); cyc();
    man_pulse = 1'b0; cyc(); cyc();
    nd0 = n_done;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("abort_seq_rst", 64'(seq_rst), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_bbdly_hold", 64'(seq_bbdly), 64'h1234);
    repeat (5) cyc();
    check("abort_no_done", 64'(n_done), 64'(nd0));
    check("abort_stays_idle", 64'(busy), 64'd0);
    sb_q.delete();
    run_vec(tbl[0], 6);

    // abort and start together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", 64'(busy), 64'd0);
    cyc();
    check("abort_start_no_arm", 64'({busy, seq_rst}), 64'b01);

    // rst during REP of the second shot.
    v = '{16'd2, 16'd1, 32'hABC, 32'd0, 16'd0, 32'd2, 1'b0, 1'b0, 2, 32'hABC};
    push_expected(v);
    set_inputs(v);
    resp_en = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      cyc();
      if (shot_idx == 16'd1 && !seq_rst) begin ok = 1'b1; break; end
    end
    check("rst_reach_run2", 64'(ok), 64'd1);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      cyc();
      if (seq_rst) begin ok = 1'b1; break; end
    end
    check("rst_reach_rep2", 64'(ok), 64'd1);
    cyc();
    rst = 1'b1;
    cyc();
    check("rst_seq_rst", 64'(seq_rst), 64'd1);
    check("rst_bbdly", 64'(seq_bbdly), 64'd0);
    check("rst_flags", 64'({shot_strobe, busy, done}), 64'd0);
    check("rst_idx", 64'({step_idx, shot_idx}), 64'd0);
    rst = 1'b0;
    resp_en = 1'b0;
    check("rst_sb_drained", 64'(sb_q.size()), 64'd0);
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
